// File: rtl/bcrypt_core_io.sv
// bcrypt_core_io: I/O front-end for the bcrypt computing core.
// The input side packs DIN_WIDTH-bit chunks from the arbiter bus into 32-bit
// words and carries the start tag along. The output side holds ID and result
// words written by the core. Once the core marks the packet done and the
// consumer asks for it, the packet is streamed out as a header beat followed
// by every word LSB-first over a DOUT_WIDTH-bit bus.
module bcrypt_core_io #(
  parameter int DIN_WIDTH  = 8,
  parameter int DOUT_WIDTH = 1,
  parameter int N_ID       = 2,
  parameter int N_RES      = 6
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  // input assembler
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_wr_en,
  input  logic                  start,
  output logic [31:0]           word_out,
  output logic                  word_valid,
  output logic                  word_start,
  // result buffer / output stream
  input  logic                  res_wr_en,
  input  logic [3:0]            res_addr,
  input  logic [31:0]           res_din,
  input  logic                  res_done,
  input  logic                  mode_cmp,
  input  logic                  cmp_match,
  output logic                  empty,
  input  logic                  rd_en,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  wr_err
);

  localparam int CHUNKS = 32 / DIN_WIDTH;
  localparam int BEATS  = 32 / DOUT_WIDTH;
  localparam int DEPTH  = N_ID + N_RES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int BW     = $clog2(BEATS) + 1;

  // Entry count as a 5-bit value so that a full 16-entry buffer still compares.
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FULL = 2'd1;
  localparam logic [1:0] S_HDR  = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  // ---------------------------------------------------------------------------
  // Input assembler
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_chnk;
  logic [31:0]   r_asm;
  logic          r_tag;
  logic [31:0]   r_word_out;
  logic          r_word_valid;
  logic          r_word_start;

  logic [31:0]   w_asm_next;
  logic          w_last_chunk;
  logic          w_tag;

  // The chunk being written replaces its own slot; every other slot keeps its
  // previously stored value. The completed word is taken from this merged view
  // so the final chunk does not have to pass through r_asm first.
  genvar gi;
  generate
    for (gi = 0; gi < CHUNKS; gi++) begin : g_slot
      assign w_asm_next[gi*DIN_WIDTH +: DIN_WIDTH] =
        (r_chnk == CW'(gi)) ? din : r_asm[gi*DIN_WIDTH +: DIN_WIDTH];
    end
  endgenerate

  assign w_last_chunk = (r_chnk == CW'(CHUNKS - 1));
  // The tag belongs to chunk 0; for single-chunk words it is taken directly.
  assign w_tag        = (r_chnk == '0) ? start : r_tag;

  // Chunk counter, slot storage and the one-cycle word_valid pulse.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_chnk       <= '0;
      r_asm        <= '0;
      r_tag        <= 1'b0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_word_start <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (din_wr_en) begin
        r_asm <= w_asm_next;
        if (r_chnk == '0) begin
          r_tag <= start;
        end
        if (w_last_chunk) begin
          r_chnk       <= '0;
          r_word_out   <= w_asm_next;
          r_word_valid <= 1'b1;
          r_word_start <= w_tag;
        end else begin
          r_chnk <= r_chnk + CW'(1);
        end
      end
    end
  end

  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign word_start = r_word_start;

  // ---------------------------------------------------------------------------
  // Result buffer and output stream
  // ---------------------------------------------------------------------------
  logic [31:0]   r_buf [0:15];
  logic [31:0]   r_rd_data;
  logic [1:0]    r_state;
  logic          r_rd_en_r;
  logic          r_mode_cmp;
  logic          r_cmp_match;
  logic          r_wr_err;
  logic [BW-1:0] r_beat_cnt;
  logic [3:0]    r_word_cnt;
  logic [31:0]   r_shift;

  logic          w_idle;
  logic          w_addr_ok;
  logic          w_buf_we;
  logic [3:0]    w_rd_addr;
  logic [4:0]    w_n_words;
  logic [4:0]    w_load_idx;
  logic [31:0]   w_load_word;
  logic          w_last_beat;
  logic          w_last_word;
  logic [DOUT_WIDTH-1:0] w_dout;
  logic          w_dout_valid;

  assign w_idle    = (r_state == S_IDLE);
  assign w_addr_ok = ({1'b0, res_addr} < DEPTH_L);
  assign w_buf_we  = w_idle && res_wr_en && w_addr_ok;

  // The buffer is only written while idle, so its contents are frozen for the
  // whole time a packet is pending or streaming.
  always_ff @(posedge CLK) begin
    if (w_buf_we) begin
      r_buf[res_addr] <= res_din;
    end
  end

  // Read port runs one word ahead of the shifter: word 0 is fetched while
  // waiting for the consumer, and word k+1 while word k is being shifted out.
  // With at least four beats per word the read is always settled in time.
  assign w_rd_addr = (r_state == S_DATA) ? (r_word_cnt + 4'd1) : 4'd0;

  // Registered buffer read.
  always_ff @(posedge CLK) begin
    r_rd_data <= r_buf[w_rd_addr];
  end

  // Compare mode truncates the packet after the IDs and a single flag word.
  assign w_n_words   = r_mode_cmp ? 5'(N_ID + 1) : DEPTH_L;
  assign w_load_idx  = (r_state == S_HDR) ? 5'd0 : ({1'b0, r_word_cnt} + 5'd1);
  assign w_load_word = (r_mode_cmp && (w_load_idx == 5'(N_ID)))
                     ? {31'b0, r_cmp_match} : r_rd_data;
  assign w_last_beat = (r_beat_cnt == BW'(BEATS - 1));
  assign w_last_word = ({1'b0, r_word_cnt} == (w_n_words - 5'd1));

  // Packet FSM, beat/word counters, shifter and the sticky write-error flag.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_en_r   <= 1'b0;
      r_mode_cmp  <= 1'b0;
      r_cmp_match <= 1'b0;
      r_wr_err    <= 1'b0;
      r_beat_cnt  <= '0;
      r_word_cnt  <= '0;
      r_shift     <= '0;
    end else begin
      // Requests only count once a packet is pending.
      r_rd_en_r <= (r_state == S_FULL) && rd_en;

      if (!w_idle && (res_wr_en || res_done)) begin
        r_wr_err <= 1'b1;
      end
      if (w_idle && res_wr_en && !w_addr_ok) begin
        r_wr_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (res_done) begin
            r_mode_cmp  <= mode_cmp;
            r_cmp_match <= cmp_match;
            r_state     <= S_FULL;
          end
        end
        S_FULL: begin
          if (r_rd_en_r) begin
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          r_shift    <= w_load_word;
          r_beat_cnt <= '0;
          r_word_cnt <= '0;
          r_state    <= S_DATA;
        end
        S_DATA: begin
          if (w_last_beat) begin
            r_beat_cnt <= '0;
            if (w_last_word) begin
              r_word_cnt <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_word_cnt <= r_word_cnt + 4'd1;
              r_shift    <= w_load_word;
            end
          end else begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
            r_shift    <= r_shift >> DOUT_WIDTH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output beat decode from the registered state.
  always_comb begin
    w_dout       = '0;
    w_dout_valid = 1'b0;
    case (r_state)
      S_HDR: begin
        w_dout       = DOUT_WIDTH'(1);
        w_dout_valid = 1'b1;
      end
      S_DATA: begin
        w_dout       = r_shift[DOUT_WIDTH-1:0];
        w_dout_valid = 1'b1;
      end
      default: begin
        w_dout       = '0;
        w_dout_valid = 1'b0;
      end
    endcase
  end

  assign empty      = w_idle;
  assign dout       = w_dout;
  assign dout_valid = w_dout_valid;
  assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_bcrypt_core_io.sv
// Testbench for bcrypt_core_io: two instances (8-in/1-out and 32-in/8-out)
// share the result-side stimulus. Expected words and packets are queued by the
// stimulus from a simple array model; a negedge monitor pops and compares.
module tb_bcrypt_core_io;

  localparam int N_ID  = 2;
  localparam int N_RES = 6;
  localparam int DEPTH = N_ID + N_RES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]  din0 = '0;
  logic        din0_wr = 1'b0, start0 = 1'b0;
  logic [31:0] din1 = '0;
  logic        din1_wr = 1'b0, start1 = 1'b0;

  logic        res_wr_en = 1'b0;
  logic [3:0]  res_addr = '0;
  logic [31:0] res_din = '0;
  logic        res_done = 1'b0, mode_cmp = 1'b0, cmp_match = 1'b0, rd_en = 1'b0;

  logic [31:0] word_out0, word_out1;
  logic        word_valid0, word_valid1, word_start0, word_start1;
  logic        empty0, empty1, dout_valid0, dout_valid1, wr_err0, wr_err1;
  logic        dout0;
  logic [7:0]  dout1;

  bcrypt_core_io #(.DIN_WIDTH(8), .DOUT_WIDTH(1), .N_ID(N_ID), .N_RES(N_RES)) dut0 (
    .CLK(clk), .rst_n(rst_n), .din(din0), .din_wr_en(din0_wr), .start(start0),
    .word_out(word_out0), .word_valid(word_valid0), .word_start(word_start0),
    .res_wr_en(res_wr_en), .res_addr(res_addr), .res_din(res_din), .res_done(res_done),
    .mode_cmp(mode_cmp), .cmp_match(cmp_match), .empty(empty0), .rd_en(rd_en),
    .dout(dout0), .dout_valid(dout_valid0), .wr_err(wr_err0));

  bcrypt_core_io #(.DIN_WIDTH(32), .DOUT_WIDTH(8), .N_ID(N_ID), .N_RES(N_RES)) dut1 (
    .CLK(clk), .rst_n(rst_n), .din(din1), .din_wr_en(din1_wr), .start(start1),
    .word_out(word_out1), .word_valid(word_valid1), .word_start(word_start1),
    .res_wr_en(res_wr_en), .res_addr(res_addr), .res_din(res_din), .res_done(res_done),
    .mode_cmp(mode_cmp), .cmp_match(cmp_match), .empty(empty1), .rd_en(rd_en),
    .dout(dout1), .dout_valid(dout_valid1), .wr_err(wr_err1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and scoreboards.
  logic [31:0] mbuf [0:DEPTH-1];
  logic [31:0] expw0[$], expw1[$];
  int          expn0[$], expn1[$];
  logic [32:0] expa0[$], expa1[$];

  // Monitor state per instance.
  int          in_pkt [2];
  int          beat_i [2];
  int          nwords [2];
  logic [31:0] acc    [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_empty_q(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT produced output but nothing was expected", nm);
  endtask

  // Packet monitor step for one instance, called every negedge.
  task automatic mon_pkt(input int idx, input logic v, input logic [7:0] d,
                         input int w, input logic emp);
    int          beats;
    logic [31:0] e;
    int          n;
    beats = 32 / w;
    if (!rst_n) begin
      in_pkt[idx] = 0;
      return;
    end
    if (v) begin
      if (in_pkt[idx] == 0) begin
        chk($sformatf("header_beat%0d", idx), {24'b0, d}, 32'd1);
        in_pkt[idx] = 1;
        beat_i[idx] = 0;
        nwords[idx] = 0;
        acc[idx]    = '0;
      end else begin
        acc[idx] = acc[idx] | ({24'b0, d} << (beat_i[idx] * w));
        beat_i[idx]++;
        if (beat_i[idx] == beats) begin
          if ((idx == 0 && expw0.size() == 0) || (idx == 1 && expw1.size() == 0)) begin
            fail_empty_q($sformatf("pkt_word%0d", idx));
          end else begin
            e = (idx == 0) ? expw0.pop_front() : expw1.pop_front();
            chk($sformatf("pkt%0d_word%0d", idx, nwords[idx]), acc[idx], e);
          end
          nwords[idx]++;
          beat_i[idx] = 0;
          acc[idx]    = '0;
        end
      end
    end else if (in_pkt[idx] != 0) begin
      if ((idx == 0 && expn0.size() == 0) || (idx == 1 && expn1.size() == 0)) begin
        fail_empty_q($sformatf("pkt_len%0d", idx));
      end else begin
        n = (idx == 0) ? expn0.pop_front() : expn1.pop_front();
        chk($sformatf("pkt%0d_len", idx), 32'(nwords[idx]), 32'(n));
      end
      chk($sformatf("pkt%0d_partial_beats", idx), 32'(beat_i[idx]), 32'd0);
      chk($sformatf("pkt%0d_empty_after", idx), {31'b0, emp}, 32'd1);
      $display("packet done on dut%0d: %0d words", idx, nwords[idx]);
      in_pkt[idx] = 0;
    end
  endtask

  // Monitor: words from both assemblers and beats from both streams.
  initial begin
    for (int i = 0; i < 2; i++) begin
      in_pkt[i] = 0; beat_i[i] = 0; nwords[i] = 0; acc[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (rst_n && word_valid0) begin
        if (expa0.size() == 0) fail_empty_q("asm0_word");
        else begin
          logic [32:0] ea;
          ea = expa0.pop_front();
          chk("asm0_word", word_out0, ea[31:0]);
          chk("asm0_start", {31'b0, word_start0}, {31'b0, ea[32]});
          $display("asm0 word 0x%08h start %0b", word_out0, word_start0);
        end
      end
      if (rst_n && word_valid1) begin
        if (expa1.size() == 0) fail_empty_q("asm1_word");
        else begin
          logic [32:0] eb;
          eb = expa1.pop_front();
          chk("asm1_word", word_out1, eb[31:0]);
          chk("asm1_start", {31'b0, word_start1}, {31'b0, eb[32]});
          $display("asm1 word 0x%08h start %0b", word_out1, word_start1);
        end
      end
      mon_pkt(0, dout_valid0, {7'b0, dout0}, 1, empty0);
      mon_pkt(1, dout_valid1, dout1, 8, empty1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    expw0.delete(); expw1.delete(); expn0.delete(); expn1.delete();
    expa0.delete(); expa1.delete();
    tick();
    chk("rst_dout_valid0", {31'b0, dout_valid0}, 32'd0);
    chk("rst_dout_valid1", {31'b0, dout_valid1}, 32'd0);
    chk("rst_empty0", {31'b0, empty0}, 32'd1);
    chk("rst_empty1", {31'b0, empty1}, 32'd1);
    chk("rst_wr_err0", {31'b0, wr_err0}, 32'd0);
    chk("rst_word_valid0", {31'b0, word_valid0}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [31:0] d);
    res_wr_en = 1'b1; res_addr = a; res_din = d;
    tick();
    res_wr_en = 1'b0;
  endtask

  // Legal load of every entry in a rotated order with random gaps.
  task automatic load_all_random();
    int off;
    logic [3:0] a;
    off = $urandom_range(0, DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) begin
      a = 4'((i + off) % DEPTH);
      mbuf[a] = $urandom;
      write_entry(a, mbuf[a]);
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  // Expected packet content derived from the model buffer.
  task automatic push_expected(input logic cmp, input logic match);
    int n;
    logic [31:0] w;
    n = cmp ? (N_ID + 1) : DEPTH;
    for (int i = 0; i < n; i++) begin
      w = (cmp && i == N_ID) ? {31'b0, match} : mbuf[i];
      expw0.push_back(w);
      expw1.push_back(w);
    end
    expn0.push_back(n);
    expn1.push_back(n);
  endtask

  task automatic finish_pkt(input logic cmp, input logic match);
    push_expected(cmp, match);
    res_done = 1'b1; mode_cmp = cmp; cmp_match = match;
    tick();
    res_done = 1'b0; mode_cmp = 1'b0; cmp_match = 1'b0;
    chk("full_empty0", {31'b0, empty0}, 32'd0);
    chk("full_empty1", {31'b0, empty1}, 32'd0);
  endtask

  // rd_en for one cycle; header must appear two cycles later, not earlier.
  task automatic read_pkt();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    chk("latency_t1_valid", {31'b0, dout_valid0}, 32'd0);
    @(negedge clk);
    chk("latency_t2_valid0", {31'b0, dout_valid0}, 32'd1);
    chk("latency_t2_valid1", {31'b0, dout_valid1}, 32'd1);
    chk("latency_t2_dout0", {31'b0, dout0}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(empty0 && empty1 && !dout_valid0 && !dout_valid1) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: timeout after %0d cycles, empty0=%0b empty1=%0b", n, empty0, empty1);
    end
    tick();
    tick();
  endtask

  task automatic send_chunk8(input logic [7:0] d, input logic s);
    din0 = d; start0 = s; din0_wr = 1'b1;
    tick();
    din0_wr = 1'b0;
  endtask

  initial begin
    logic [7:0]  bytes [0:3];
    logic [31:0] w;
    logic        s;

    tick();
    apply_reset();
    chk("rst_word_out0", word_out0, 32'd0);
    chk("rst_dout0", {31'b0, dout0}, 32'd0);

    // Directed assembly: 0x78,0x56,0x34,0x12 with start on chunk 0.
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    expa0.push_back({1'b1, 32'h12345678});
    for (int i = 0; i < 4; i++) send_chunk8(bytes[i], (i == 0));
    chk("asm_pulse_t1", {31'b0, word_valid0}, 32'd1);
    tick();
    chk("asm_pulse_t2", {31'b0, word_valid0}, 32'd0);

    // Random words on the 8-bit side, gaps and stray start bits on chunks 1..3.
    for (int k = 0; k < 12; k++) begin
      w = $urandom;
      s = 1'($urandom_range(0, 1));
      expa0.push_back({s, w});
      for (int i = 0; i < 4; i++) begin
        send_chunk8(w[8*i +: 8], (i == 0) ? s : 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
      end
    end
    // Random words on the 32-bit side, mostly back-to-back.
    for (int k = 0; k < 12; k++) begin
      w = $urandom;
      s = 1'($urandom_range(0, 1));
      expa1.push_back({s, w});
      din1 = w; start1 = s; din1_wr = 1'b1;
      tick();
      din1_wr = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick(); tick();

    // Directed normal packet.
    mbuf[0] = 32'hA5A5A5A5; mbuf[1] = 32'h00000001;
    for (int i = 0; i < N_RES; i++) mbuf[N_ID + i] = 32'(i + 1);
    for (int i = 0; i < DEPTH; i++) write_entry(4'(i), mbuf[i]);
    finish_pkt(1'b0, 1'b0);
    read_pkt();
    wait_idle();

    // Compare mode with a match.
    load_all_random();
    finish_pkt(1'b1, 1'b1);
    read_pkt();
    wait_idle();

    // Last entry written in the same cycle as res_done.
    for (int i = 0; i < DEPTH - 1; i++) begin
      mbuf[i] = $urandom;
      write_entry(4'(i), mbuf[i]);
    end
    mbuf[7] = $urandom;
    push_expected(1'b0, 1'b0);
    res_wr_en = 1'b1; res_addr = 4'd7; res_din = mbuf[7]; res_done = 1'b1;
    tick();
    res_wr_en = 1'b0; res_done = 1'b0;
    read_pkt();
    wait_idle();

    // Out-of-range writes in idle are dropped and flagged.
    chk("wr_err_before_oor", {31'b0, wr_err0}, 32'd0);
    write_entry(4'd9, 32'hDEAD0009);
    write_entry(4'd12, 32'hDEAD000C);
    chk("wr_err_oor0", {31'b0, wr_err0}, 32'd1);
    chk("wr_err_oor1", {31'b0, wr_err1}, 32'd1);
    finish_pkt(1'b0, 1'b0);
    read_pkt();
    wait_idle();

    // Reset in the middle of DATA aborts the packet.
    load_all_random();
    finish_pkt(1'b0, 1'b0);
    read_pkt();
    repeat (10) tick();
    apply_reset();
    repeat (300) tick();
    chk("post_abort_valid0", {31'b0, dout_valid0}, 32'd0);
    chk("post_abort_empty0", {31'b0, empty0}, 32'd1);

    // Illegal write and done during DATA: flagged, packet unchanged.
    load_all_random();
    finish_pkt(1'b0, 1'b0);
    read_pkt();
    chk("wr_err_before_data_write", {31'b0, wr_err0}, 32'd0);
    repeat (3) tick();
    res_wr_en = 1'b1; res_addr = 4'd2; res_din = $urandom; res_done = 1'b1; mode_cmp = 1'b1;
    tick();
    res_wr_en = 1'b0; res_done = 1'b0; mode_cmp = 1'b0;
    chk("wr_err_data0", {31'b0, wr_err0}, 32'd1);
    chk("wr_err_data1", {31'b0, wr_err1}, 32'd1);
    wait_idle();
    chk("empty_after_illegal0", {31'b0, empty0}, 32'd1);

    // Following packets load normally; random modes.
    for (int p = 0; p < 4; p++) begin
      load_all_random();
      finish_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      read_pkt();
      wait_idle();
    end

    repeat (5) tick();
    chk("scoreboard_words0_drained", 32'(expw0.size()), 32'd0);
    chk("scoreboard_words1_drained", 32'(expw1.size()), 32'd0);
    chk("scoreboard_asm_drained", 32'(expa0.size() + expa1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
